// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light phase controller.
//   - tl_state_e : controller states; the enum value is the encoding shown on `phase`
//   - lamp_t     : lamp vector with main-road, side-road and pedestrian fields
//   - DEF_*      : default dwell times, in time-base ticks
//   - lamp_decode: maps a state to its lamp pattern (exactly one lamp per road)
package tl_pkg;

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    ALL_R1 = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    PED_W  = 3'd5,
    ALL_R2 = 3'd6
  } tl_state_e;

  // Identifies which service was granted most recently; used to break ties.
  typedef enum logic {
    SRV_SIDE = 1'b0,
    SRV_PED  = 1'b1
  } srv_e;

  typedef struct packed {
    logic g;
    logic y;
    logic r;
  } road_lamp_t;

  typedef struct packed {
    road_lamp_t main_lamp;
    road_lamp_t side_lamp;
    logic       ped_walk;
  } lamp_t;

  localparam int DEF_GREEN_MIN = 8;
  localparam int DEF_YELLOW_T  = 3;
  localparam int DEF_ALLRED_T  = 2;
  localparam int DEF_SIDE_T    = 6;
  localparam int DEF_PED_T     = 5;
  localparam int DEF_CNT_W     = 8;

  function automatic lamp_t lamp_decode(input tl_state_e st);
    lamp_t l;
    l = '0;
    unique case (st)
      MAIN_G: begin
        l.main_lamp.g = 1'b1;
        l.side_lamp.r = 1'b1;
      end
      MAIN_Y: begin
        l.main_lamp.y = 1'b1;
        l.side_lamp.r = 1'b1;
      end
      SIDE_G: begin
        l.main_lamp.r = 1'b1;
        l.side_lamp.g = 1'b1;
      end
      SIDE_Y: begin
        l.main_lamp.r = 1'b1;
        l.side_lamp.y = 1'b1;
      end
      PED_W: begin
        l.main_lamp.r = 1'b1;
        l.side_lamp.r = 1'b1;
        l.ped_walk    = 1'b1;
      end
      default: begin
        // ALL_R1 / ALL_R2 clearance: both roads red.
        l.main_lamp.r = 1'b1;
        l.side_lamp.r = 1'b1;
      end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_timer.sv
// Loadable, tick-enabled down-counter used as the phase dwell timer.
//   clk, rst_n : clock, asynchronous active-low reset (counter -> RST_VAL)
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to load, normally dwell-1 of the state being entered
//   tick       : time-base strobe; the counter only moves in tick cycles
//   expired    : counter is zero (the dwell is complete on the next tick)
module tl_timer #(
  parameter int              CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      // Saturates at zero: a held state keeps reporting expiry.
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/tl_phase_ctrl.sv
// Phase controller for a two-road intersection with a pedestrian crossing.
// Sequences MAIN_G -> MAIN_Y -> ALL_R1 -> (SIDE_G -> SIDE_Y | PED_W) -> ALL_R2
// -> MAIN_G, leaving MAIN_G only once its minimum dwell is done and a request
// is pending. Dwell times are counted in ticks of an external strobe.
//   clk, rst_n          : clock, asynchronous active-low reset
//   tick                : time-base strobe; state and timer move only when high
//   side_req, ped_req   : service requests, sampled every clk (tick-independent)
//   main_g/y/r          : main-road lamps
//   side_g/y/r          : side-road lamps
//   ped_walk            : pedestrian walk lamp
//   phase               : current state encoding (debug / display)
//   side_pend, ped_pend : latched pending requests
// Requests are plain level/pulse inputs with no handshake: any cycle with a
// request high sets the matching pending flag unless that service is active.
module tl_phase_ctrl
  import tl_pkg::*;
#(
  parameter int GREEN_MIN = DEF_GREEN_MIN,
  parameter int YELLOW_T  = DEF_YELLOW_T,
  parameter int ALLRED_T  = DEF_ALLRED_T,
  parameter int SIDE_T    = DEF_SIDE_T,
  parameter int PED_T     = DEF_PED_T,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       side_req,
  input  logic       ped_req,
  output logic       main_g,
  output logic       main_y,
  output logic       main_r,
  output logic       side_g,
  output logic       side_y,
  output logic       side_r,
  output logic       ped_walk,
  output logic [2:0] phase,
  output logic       side_pend,
  output logic       ped_pend
);

  // Timer load values are dwell-1 so a state lasts exactly `dwell` ticks.
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] SIDE_LD   = CNT_W'(SIDE_T - 1);
  localparam logic [CNT_W-1:0] PED_LD    = CNT_W'(PED_T - 1);

  tl_state_e        state;
  tl_state_e        state_nxt;
  srv_e             last_srv;
  logic             expired;
  logic             advance;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  lamp_t            lamps;

  function automatic logic [CNT_W-1:0] entry_load(input tl_state_e st);
    logic [CNT_W-1:0] v;
    unique case (st)
      MAIN_G:         v = GREEN_LD;
      MAIN_Y, SIDE_Y: v = YELLOW_LD;
      SIDE_G:         v = SIDE_LD;
      PED_W:          v = PED_LD;
      default:        v = ALLRED_LD;
    endcase
    return v;
  endfunction

  // A dwell completes in a tick cycle whose timer already reads zero.
  assign advance = tick && expired;

  always_comb begin
    state_nxt = state;
    if (advance) begin
      unique case (state)
        MAIN_G: if (side_pend || ped_pend) state_nxt = MAIN_Y;
        MAIN_Y: state_nxt = ALL_R1;
        ALL_R1: begin
          // Single pending request is served directly; a tie goes to the
          // service that did not run last.
          if (side_pend && ped_pend)
            state_nxt = (last_srv == SRV_PED) ? SIDE_G : PED_W;
          else if (side_pend)
            state_nxt = SIDE_G;
          else
            state_nxt = PED_W;
        end
        SIDE_G: state_nxt = SIDE_Y;
        SIDE_Y: state_nxt = ALL_R2;
        PED_W:  state_nxt = ALL_R2;
        default: state_nxt = MAIN_G;
      endcase
    end
  end

  // MAIN_G held for lack of a request does not reload: the timer stays at 0.
  assign tmr_load     = (state_nxt != state);
  assign tmr_load_val = entry_load(state_nxt);

  tl_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (GREEN_LD)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .tick     (tick),
    .expired  (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MAIN_G;
      last_srv  <= SRV_PED;
      side_pend <= 1'b0;
      ped_pend  <= 1'b0;
    end else begin
      state <= state_nxt;

      if (tmr_load && (state_nxt == SIDE_G)) last_srv <= SRV_SIDE;
      else if (tmr_load && (state_nxt == PED_W)) last_srv <= SRV_PED;

      // The flag stays up through the first cycle of its service and is
      // cleared while that service runs; requests seen then are absorbed.
      if (state == SIDE_G)  side_pend <= 1'b0;
      else if (side_req)    side_pend <= 1'b1;

      if (state == PED_W)   ped_pend <= 1'b0;
      else if (ped_req)     ped_pend <= 1'b1;
    end
  end

  // Lamps decode the state register directly, so an asynchronous reset
  // shows the MAIN_G pattern immediately.
  assign lamps    = lamp_decode(state);
  assign main_g   = lamps.main_lamp.g;
  assign main_y   = lamps.main_lamp.y;
  assign main_r   = lamps.main_lamp.r;
  assign side_g   = lamps.side_lamp.g;
  assign side_y   = lamps.side_lamp.y;
  assign side_r   = lamps.side_lamp.r;
  assign ped_walk = lamps.ped_walk;
  assign phase    = state;

endmodule

// File: tb/tb_tl_phase_ctrl.sv
module tb_tl_phase_ctrl;

  localparam int GM = 4;
  localparam int YT = 2;
  localparam int AT = 1;
  localparam int ST = 3;
  localparam int PT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic side_req = 1'b0;
  logic ped_req = 1'b0;
  logic main_g, main_y, main_r, side_g, side_y, side_r, ped_walk;
  logic [2:0] phase;
  logic side_pend, ped_pend;

  always #5 clk = ~clk;

  tl_phase_ctrl #(
    .GREEN_MIN (GM),
    .YELLOW_T  (YT),
    .ALLRED_T  (AT),
    .SIDE_T    (ST),
    .PED_T     (PT),
    .CNT_W     (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .side_req  (side_req),
    .ped_req   (ped_req),
    .main_g    (main_g),
    .main_y    (main_y),
    .main_r    (main_r),
    .side_g    (side_g),
    .side_y    (side_y),
    .side_r    (side_r),
    .ped_walk  (ped_walk),
    .phase     (phase),
    .side_pend (side_pend),
    .ped_pend  (ped_pend)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase numbers: 0 main green, 1 main yellow, 2 all-red before service,
  // 3 side green, 4 side yellow, 5 walk, 6 all-red after service.
  int m_ph;        // current phase
  int m_ticks;     // ticks already spent in the current phase
  bit m_sp, m_pp;  // pending requests
  bit m_last_ped;  // most recent service was pedestrian

  function automatic int dwell(input int ph);
    case (ph)
      0: return GM;
      1, 4: return YT;
      3: return ST;
      5: return PT;
      default: return AT;
    endcase
  endfunction

  // {main g,y,r, side g,y,r, walk}
  function automatic int exp_lamps(input int ph);
    case (ph)
      0: return 7'b100_001_0;
      1: return 7'b010_001_0;
      3: return 7'b001_100_0;
      4: return 7'b001_010_0;
      5: return 7'b001_001_1;
      default: return 7'b001_001_0;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = 0;
    m_ticks = 0;
    m_sp = 1'b0;
    m_pp = 1'b0;
    m_last_ped = 1'b1;
  endtask

  // Advances the model by one clock given this cycle's inputs.
  task automatic model_step(input bit t, input bit s, input bit p);
    int nph;
    nph = m_ph;
    if (t) begin
      if (m_ticks + 1 >= dwell(m_ph)) begin
        // The full dwell has been served; decide where to go.
        case (m_ph)
          0: if (m_sp || m_pp) nph = 1;
          1: nph = 2;
          2: begin
            if (m_sp && m_pp) nph = m_last_ped ? 3 : 5;
            else if (m_sp)    nph = 3;
            else              nph = 5;
          end
          3: nph = 4;
          4: nph = 6;
          5: nph = 6;
          default: nph = 0;
        endcase
        if (nph == m_ph) m_ticks = dwell(m_ph) - 1;
      end else begin
        m_ticks++;
      end
    end
    m_sp = (m_ph == 3) ? 1'b0 : (m_sp | s);
    m_pp = (m_ph == 5) ? 1'b0 : (m_pp | p);
    if (nph != m_ph) begin
      m_ticks = 0;
      if (nph == 3) m_last_ped = 1'b0;
      if (nph == 5) m_last_ped = 1'b1;
    end
    m_ph = nph;
  endtask

  // ---------------- driver tasks ----------------
  function automatic int lamp_vec();
    return {main_g, main_y, main_r, side_g, side_y, side_r, ped_walk};
  endfunction

  task automatic check_all();
    chk("phase", int'(phase), m_ph);
    chk("lamps", lamp_vec(), exp_lamps(m_ph));
    chk("side_pend", int'(side_pend), int'(m_sp));
    chk("ped_pend", int'(ped_pend), int'(m_pp));
  endtask

  // Called at a falling edge: check, drive this cycle's inputs, step model.
  task automatic cyc(input bit t, input bit s, input bit p);
    check_all();
    tick = t;
    side_req = s;
    ped_req = p;
    model_step(t, s, p);
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick = 1'b0;
    side_req = 1'b0;
    ped_req = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_phase", int'(phase), 0);
    chk("rst_lamps", lamp_vec(), 7'b100_001_0);
    chk("rst_pend", int'({side_pend, ped_pend}), 0);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int side_ph[15];
    side_ph = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 4, 4, 6, 0, 0};

    // Idle
    do_reset();
    for (int c = 0; c < 30; c++) begin
      chk("idle_phase", int'(phase), 0);
      chk("idle_lamp", int'({main_g, side_r}), 3);
      cyc(1'b1, 1'b0, 1'b0);
    end

    // Side only
    do_reset();
    for (int c = 0; c < 15; c++) begin
      chk("side_seq", int'(phase), side_ph[c]);
      chk("side_pend_win", int'(side_pend), (c >= 2 && c <= 7) ? 1 : 0);
      cyc(1'b1, c == 1, 1'b0);
    end

    // Tie: side first, then pedestrian after one minimum main green
    do_reset();
    for (int c = 0; c < 25; c++) begin
      if (c == 7) chk("tie_side_first", int'(phase), 3);
      if (c >= 13 && c <= 16) chk("tie_main_g", int'(phase), 0);
      if (c >= 20 && c <= 22) begin
        chk("tie_ped_phase", int'(phase), 5);
        chk("tie_walk", int'(ped_walk), 1);
      end
      if (c == 23) chk("tie_walk_end", int'(ped_walk), 0);
      cyc(1'b1, c == 1, c == 1);
    end

    // Tick gating: tick every 3rd cycle, ped request on a tick-low cycle
    do_reset();
    for (int c = 0; c < 45; c++) begin
      if (c == 3) chk("gate_ped_latched", int'(ped_pend), 1);
      if (c == 9) chk("gate_main_hold", int'(phase), 0);
      if (c == 10) chk("gate_main_y", int'(phase), 1);
      if (c == 18) chk("gate_allr", int'(phase), 2);
      if (c == 19) chk("gate_side_g", int'(phase), 3);
      cyc((c % 3) == 0, c == 1, c == 2);
    end

    // Absorption: side request during SIDE_G is dropped, ped request is kept
    do_reset();
    for (int c = 0; c < 33; c++) begin
      if (c == 9) begin
        chk("abs_side_pend", int'(side_pend), 0);
        chk("abs_ped_pend", int'(ped_pend), 1);
      end
      if (c == 20) chk("abs_ped_w", int'(phase), 5);
      if (c >= 24) chk("abs_no_side", int'(phase), 0);
      cyc(1'b1, (c == 1) || (c == 8), c == 8);
    end

    // Asynchronous reset in the middle of SIDE_G
    do_reset();
    for (int c = 0; c < 8; c++) cyc(1'b1, c == 1, c == 1);
    chk("arst_in_side", int'(phase), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_main_g", int'(main_g), 1);
    chk("arst_side_g", int'(side_g), 0);
    chk("arst_pend", int'({side_pend, ped_pend}), 0);
    chk("arst_phase", int'(phase), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      chk("arst_idle", int'(phase), 0);
      cyc(1'b1, 1'b0, 1'b0);
    end

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      cyc($urandom_range(0, 1) == 1,
          $urandom_range(0, 24) == 0,
          $urandom_range(0, 19) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tl_phase_ctrl.md
# tl_phase_ctrl

Phase controller for the two-road traffic-light intersection. It sequences main-road green, yellow and all-red phases, a side-road green phase and a pedestrian walk phase. It arbitrates between side-road vehicle requests (single-cycle match pulses from the pattern detectors) and pedestrian push-button requests. All dwell times are counted in ticks of an external time-base strobe.

## Interface
- `GREEN_MIN`, 8: minimum main-green dwell, in ticks (≥1).
- `YELLOW_T`, 3: yellow dwell, in ticks (≥1).
- `ALLRED_T`, 2: all-red clearance dwell, in ticks (≥1).
- `SIDE_T`, 6: side-green dwell, in ticks (≥1).
- `PED_T`, 5: pedestrian-walk dwell, in ticks (≥1).
- `CNT_W`, 8: timer width. Every dwell must be ≤ 2^CNT_W.

- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tick` in 1: time-base strobe. Timers advance only in cycles where `tick` is high.
- `side_req` in 1: side-road vehicle request pulse, sampled every clk.
- `ped_req` in 1: pedestrian request, level or pulse, sampled every clk.
- `main_g`, `main_y`, `main_r` out 1 each: main-road lamps.
- `side_g`, `side_y`, `side_r` out 1 each: side-road lamps.
- `ped_walk` out 1: pedestrian walk lamp.
- `phase` out 3: current state encoding, for debug and display.
- `side_pend`, `ped_pend` out 1 each: latched pending requests.

## Operation
- States are MAIN_G, MAIN_Y, ALL_R1, SIDE_G, SIDE_Y, PED_W and ALL_R2. Encoding is 0–6 in that order on `phase`.
- Lamps are a combinational decode of the state register. Exactly one lamp per road is lit.
  - MAIN_G: `main_g`, `side_r`.
  - MAIN_Y: `main_y`, `side_r`.
  - ALL_R1, ALL_R2, PED_W: `main_r`, `side_r`. PED_W additionally lights `ped_walk`.
  - SIDE_G: `main_r`, `side_g`.
  - SIDE_Y: `main_r`, `side_y`.
- Timer behaviour:
  - On entry to a state, the timer loads `dwell-1`.
  - In a tick cycle, a timer value of 0 means the dwell has expired; a nonzero value decrements.
  - A state therefore lasts exactly `dwell` ticks.
- Transitions, taken only in a tick cycle with an expired timer:
  - MAIN_G→MAIN_Y only if `side_pend|ped_pend`. Otherwise MAIN_G holds with the timer at 0 and leaves on the first tick after a request latches.
  - MAIN_Y→ALL_R1.
  - ALL_R1→SIDE_G or PED_W, per arbitration.
  - SIDE_G→SIDE_Y→ALL_R2.
  - PED_W→ALL_R2.
  - ALL_R2→MAIN_G.
- Arbitration at ALL_R1 exit:
  - If only one request is pending, serve it.
  - If both are pending, serve the one opposite to `last_srv`. `last_srv` resets to PED, so the side road wins the first tie.
  - `last_srv` updates on entry to SIDE_G or PED_W.
- Pending flags:
  - `side_pend` sets on `side_req` when state≠SIDE_G and clears on the transition into SIDE_G.
  - `ped_pend` sets on `ped_req` when state≠PED_W and clears on the transition into PED_W.
  - If a request coincides with the entry cycle of its own service, the clear wins and the request is absorbed.
  - Requests for the other service are latched in any state.
- Reset (asynchronous, any state): state goes to MAIN_G, the timer loads `GREEN_MIN-1`, both pending flags clear, and `last_srv` is set to PED.
  - Outputs during reset: `main_g`=1, `side_r`=1, all other lamps 0, `phase`=0.

## Timing
- Request to flag: `*_pend` rises the cycle after the `*_req` edge. `tick` does not gate this.
- Request to leaving MAIN_G: at the first tick cycle where both the timer is 0 and a request is pending. Minimum main-green is always honoured.
- With `tick` tied high, each dwell equals its parameter value in clock cycles.
- With `tick` low, state and timer freeze, but request latching continues.

## Structure
- Shared package `tl_pkg` holds:
  - the state enum and `phase` encoding;
  - a lamp-vector typedef with main, side and ped fields;
  - default dwell constants.
- Sub-module `tl_timer`: loadable, tick-enabled down-counter with `load`, `load_val`, `tick` and `expired` (== 0) ports, `CNT_W` wide.
- The top level contains the FSM, pending flags, arbiter and lamp decode.

## Test plan
Common setup: `GREEN_MIN`=4, `YELLOW_T`=2, `ALLRED_T`=1, `SIDE_T`=3, `PED_T`=3, `tick`=1. Cycle 0 is the first cycle after reset release.

- **Idle:** no requests for 30 cycles → `phase`=0, `main_g`=`side_r`=1 throughout.
- **Side only:** `side_req` pulse at cycle 1 →
  - MAIN_G cycles 0–3, MAIN_Y 4–5, ALL_R1 6, SIDE_G 7–9, SIDE_Y 10–11, ALL_R2 12, MAIN_G from 13;
  - `side_pend` high cycles 2–7.
- **Tie:** `side_req` and `ped_req` at cycle 1 → SIDE_G served first, MAIN_G from 13 for 4 cycles, then PED_W with `ped_walk`=1 for 3 cycles.
- **Tick gating:** `tick` high every 3rd cycle, side request → every dwell stretches 3×; `ped_req` during a `tick`-low cycle is still latched.
- **Absorption:** `side_req` during SIDE_G → no second side service. `ped_req` during SIDE_G → `ped_pend`=1 and PED_W follows the next minimum main-green.
- **Async reset:** `rst_n` low mid SIDE_G → same cycle `main_g`=1, `side_g`=0, pending flags 0. After release, the normal idle behaviour follows.
